conv_relu_pool: RTL and testbench
=================================

// Module: conv_relu_pool
// PURPOSE
//  Post-processing stage that sits directly downstream of conv.
//  - Consumes the raster-ordered result stream conv emits (output_data qualified by output_req).
//  - Applies ReLU, then 2x2 stride-2 max pooling.
//  - Emits the pooled map with sequential write addresses for the next layer's buffer.
//  - Holds one half-width line buffer, so the previous row is never re-read from memory.
// PARAMETERS
//  DATA_W   20   conv result width (matches conv output_data)
//  MAP_W    30   conv output map width, samples per row (>=2)
//  MAP_H    30   conv output map height, rows (>=2)
//  ADDR_W   10   pool_addr width
//  SIGNED   1    1: in_data is two's complement, ReLU active; 0: unsigned, ReLU bypassed
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  reset      in   1       asynchronous, active-low; clears all state
//  start      in   1       level/pulse, same net as conv start; arms a new frame
//  in_data    in   DATA_W  conv result sample
//  in_valid   in   1       sample strobe (conv output_req); one sample per cycle high
//  pool_data  out  DATA_W  pooled value, always >=0 when SIGNED=1
//  pool_addr  out  ADDR_W  write address of pool_data, 0..(MAP_W/2)*(MAP_H/2)-1
//  pool_req   out  1       pool_data/pool_addr valid this cycle (write strobe)
//  done       out  1       one-cycle pulse: frame complete
// BEHAVIOUR
//  Reset values
//  - pool_data=0, pool_addr=0, pool_req=0, done=0.
//  - FSM=IDLE; col, row and sample counters =0; line buffer contents don't-care.
//  FSM
//  - IDLE: in_valid ignored. start=1 -> RUN; clears col, row, out address counter.
//  - RUN: each in_valid=1 cycle accepts one sample; start ignored.
//    On acceptance of sample MAP_W*MAP_H -> FLUSH.
//  - FLUSH: one cycle; done=1 -> IDLE. A start seen in FLUSH is ignored.
//  ReLU (combinational on accept)
//  - r = (SIGNED && in_data[DATA_W-1]) ? 0 : in_data.
//  - Comparisons are unsigned on r (valid because r>=0); no width growth.
//  Pooling (col, row = position of the accepted sample)
//  - col even: hold r in pair register h.
//  - col odd: m = max(h,r).
//    * row even: lb[col>>1] <= m.
//    * row odd: result = max(lb[col>>1], m).
//  - MAP_W odd: last column of each row discarded (no lb write, no output).
//  - MAP_H odd: last row discarded.
//  - Line buffer: MAP_W/2 entries x DATA_W; written in even rows, read in odd rows.
//    A slot's read and rewrite never fall in the same cycle.
//  Output timing
//  - pool_req=1 exactly one cycle after the accepted sample that completes a window.
//    pool_data=result and pool_addr=out counter are registered on that same edge.
//  - Out counter increments after each pool_req; no wrap within a frame.
//  - Gaps in in_valid stall the pipeline; no sample is lost or duplicated.
//  - pool_req is never asserted in IDLE.
//  Frame end
//  - FLUSH is entered on the edge that accepts the last sample.
//  - Even dims: done coincides with the final pool_req.
//  - Odd dims: done is one cycle after the last accepted sample.
//  Reset mid-frame
//  - Aborts immediately; no partial output or done follows.
//  - Next frame requires start again.
// TESTING (MAP_W=4, MAP_H=4, DATA_W=20, SIGNED=1 unless stated)
//  1) start, then 16 back-to-back samples 1..16 ->
//     pool_req x4, data 6,8,14,16 at addr 0..3; done with the 4th pool_req.
//  2) All 16 samples = -5 (0xFFFFB) -> four outputs of 0 (ReLU clamp).
//  3) Test 1 stream with in_valid=0 every other cycle -> same data/addr; each pool_req 1 cycle after its window's last sample.
//  4) MAP_W=5, MAP_H=5, samples 1..25 -> outputs 7,9,17,19 at addr 0..3;
//     col 4 and row 4 dropped; done one cycle after sample 25.
//  5) reset low after sample 10 of test 1, restart -> no stale output; next frame gives 6,8,14,16 at addr 0..3.
//  6) in_valid pulses while IDLE, and start re-asserted during RUN -> no pool_req, frame unaffected.

Source files
------------

// File: rtl/conv_relu_pool_if.sv
// conv_relu_pool_if -- stream bundle between conv, conv_relu_pool and the
// next layer's buffer.
//   start      arms a new frame (same net as conv start)
//   in_data    conv result sample
//   in_valid   sample strobe, one sample per high cycle
//   pool_data  pooled value
//   pool_addr  write address of pool_data
//   pool_req   pool_data/pool_addr valid this cycle
//   done       one-cycle end-of-frame pulse
// slave: the pooling stage. master: whoever feeds it and takes its results.
interface conv_relu_pool_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 10
);
    logic              start;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] pool_data;
    logic [ADDR_W-1:0] pool_addr;
    logic              pool_req;
    logic              done;

    modport slave (
        input  start, in_data, in_valid,
        output pool_data, pool_addr, pool_req, done
    );

    modport master (
        output start, in_data, in_valid,
        input  pool_data, pool_addr, pool_req, done
    );
endinterface

// File: rtl/conv_relu_pool.sv
// conv_relu_pool -- ReLU followed by 2x2 stride-2 max pooling on the raster
// stream produced by conv. The pooled map leaves with sequential addresses.
// Only half a row of pair maxima is buffered, so no row is re-read.
//   clk    rising-edge clock
//   reset  asynchronous, active-low, clears all control state
//   bus    conv_relu_pool_if.slave (start/in_* in, pool_*/done out)
module conv_relu_pool #(
    parameter int DATA_W = 20,
    parameter int MAP_W  = 30,
    parameter int MAP_H  = 30,
    parameter int ADDR_W = 10,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             reset,
    conv_relu_pool_if.slave  bus
);
    localparam int COL_W = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int ROW_W = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int LB_N  = MAP_W / 2;
    localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;
    // Rows that take part in pooling; an odd last row is dropped.
    localparam int USE_H = (MAP_H / 2) * 2;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

    // Negative samples clamp to zero only for a signed stream.
    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
        if ((SIGNED != 0) && v[DATA_W-1]) begin
            relu = '0;
        end else begin
            relu = v;
        end
    endfunction

    // Plain unsigned max; operands are non-negative after ReLU.
    function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        if (a > b) begin
            umax = a;
        end else begin
            umax = b;
        end
    endfunction

    state_t            state_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [ADDR_W-1:0] out_cnt_q;
    logic [DATA_W-1:0] h_q;
    logic [DATA_W-1:0] lb_q [LB_N];
    logic [DATA_W-1:0] pool_data_q;
    logic [ADDR_W-1:0] pool_addr_q;
    logic              pool_req_q;
    logic              done_q;

    logic              accept_s;
    logic [DATA_W-1:0] relu_s;
    logic [LB_AW-1:0]  lb_idx_s;
    logic [DATA_W-1:0] pair_max_s;
    logic [DATA_W-1:0] win_max_s;
    logic              row_used_s;
    logic              last_col_s;
    logic              last_row_s;

    // Datapath for the sample presented this cycle.
    always_comb begin
        accept_s   = (state_q == RUN) && bus.in_valid;
        relu_s     = relu(bus.in_data);
        lb_idx_s   = LB_AW'(col_q >> 1);
        pair_max_s = umax(h_q, relu_s);
        win_max_s  = umax(lb_q[lb_idx_s], pair_max_s);
        row_used_s = int'(row_q) < USE_H;
        last_col_s = int'(col_q) == (MAP_W - 1);
        last_row_s = int'(row_q) == (MAP_H - 1);
    end

    // Line buffer: pair maxima of an even row, consumed by the following odd
    // row. Odd columns only exist below MAP_W/2*2, so every odd col is used.
    always_ff @(posedge clk) begin
        if (accept_s && col_q[0] && !row_q[0] && row_used_s) begin
            lb_q[lb_idx_s] <= pair_max_s;
        end
    end

    // Frame FSM, raster counters, pair register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            out_cnt_q   <= '0;
            h_q         <= '0;
            pool_data_q <= '0;
            pool_addr_q <= '0;
            pool_req_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pool_req_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q   <= RUN;
                        col_q     <= '0;
                        row_q     <= '0;
                        out_cnt_q <= '0;
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        if (!col_q[0]) begin
                            h_q <= relu_s;
                        end else if (row_q[0] && row_used_s) begin
                            pool_req_q  <= 1'b1;
                            pool_data_q <= win_max_s;
                            pool_addr_q <= out_cnt_q;
                            out_cnt_q   <= out_cnt_q + ADDR_W'(1);
                        end
                        if (last_col_s) begin
                            col_q <= '0;
                            if (last_row_s) begin
                                // done rides alongside the final pool_req.
                                row_q   <= '0;
                                state_q <= FLUSH;
                                done_q  <= 1'b1;
                            end else begin
                                row_q <= row_q + ROW_W'(1);
                            end
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.pool_data = pool_data_q;
    assign bus.pool_addr = pool_addr_q;
    assign bus.pool_req  = pool_req_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_conv_relu_pool.sv
module tb_conv_relu_pool;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [19:0] smp [0:24];

    conv_relu_pool_if #(.DATA_W(20), .ADDR_W(10)) b4 ();
    conv_relu_pool_if #(.DATA_W(20), .ADDR_W(10)) b5 ();

    conv_relu_pool #(.DATA_W(20), .MAP_W(4), .MAP_H(4), .ADDR_W(10), .SIGNED(1)) dut4 (
        .clk(clk), .reset(reset), .bus(b4));
    conv_relu_pool #(.DATA_W(20), .MAP_W(5), .MAP_H(5), .ADDR_W(10), .SIGNED(1)) dut5 (
        .clk(clk), .reset(reset), .bus(b5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic st, input logic v, input logic [19:0] d);
        if (sel == 0) begin
            b4.start = st; b4.in_valid = v; b4.in_data = d;
        end else begin
            b5.start = st; b5.in_valid = v; b5.in_data = d;
        end
    endtask

    task automatic expect_out(input int sel, input string tag, input logic req_e,
                              input logic [19:0] d_e, input logic [9:0] a_e, input logic done_e);
        logic       req;
        logic       dn;
        logic [19:0] d;
        logic [9:0]  a;
        if (sel == 0) begin
            req = b4.pool_req; dn = b4.done; d = b4.pool_data; a = b4.pool_addr;
        end else begin
            req = b5.pool_req; dn = b5.done; d = b5.pool_data; a = b5.pool_addr;
        end
        check({tag, ".req"}, 32'(req), 32'(req_e));
        check({tag, ".done"}, 32'(dn), 32'(done_e));
        if (req_e) begin
            check({tag, ".data"}, 32'(d), 32'(d_e));
            check({tag, ".addr"}, 32'(a), 32'(a_e));
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 ns after the edge.
    task automatic step(input int sel, input logic st, input logic v, input logic [19:0] d);
        set_in(sel, st, v, d);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] relu_m(input logic [19:0] v);
        return ($signed(v) < 0) ? 20'd0 : v;
    endfunction

    // Reference: max of the ReLU'd 2x2 window whose bottom-right corner is (row,col).
    function automatic logic [19:0] window_max(input int w, input int row, input int col);
        logic [19:0] m;
        m = 20'd0;
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                if (relu_m(smp[(row - dr) * w + (col - dc)]) > m)
                    m = relu_m(smp[(row - dr) * w + (col - dc)]);
            end
        end
        return m;
    endfunction

    // gap_mode: 0 back-to-back, 1 one idle cycle between samples, 2 random 0..2.
    // poke: assert start inside RUN and FLUSH, then feed in_valid while IDLE.
    task automatic run_frame(input int sel, input int w, input int h, input int gap_mode,
                             input bit poke, input int abort_at, input string tag);
        int n;
        int addr;
        int gaps;
        int col;
        int row;
        bit win;
        n = w * h;
        addr = 0;
        step(sel, 1'b1, 1'b0, 20'd0);
        expect_out(sel, {tag, ".start"}, 1'b0, 20'd0, 10'd0, 1'b0);
        for (int k = 0; k < n; k++) begin
            gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? ((k == 0) ? 0 : 1) : int'($urandom_range(2, 0));
            for (int g = 0; g < gaps; g++) begin
                step(sel, poke, 1'b0, 20'($urandom));
                expect_out(sel, {tag, ".gap"}, 1'b0, 20'd0, 10'd0, 1'b0);
            end
            step(sel, poke && (k % 3 == 0), 1'b1, smp[k]);
            col = k % w;
            row = k / w;
            win = (col % 2 == 1) && (row % 2 == 1) && (row < (h / 2) * 2);
            if (win) begin
                expect_out(sel, $sformatf("%s.s%0d", tag, k), 1'b1, window_max(w, row, col),
                           10'(addr), k == n - 1);
                addr++;
            end else begin
                expect_out(sel, $sformatf("%s.s%0d", tag, k), 1'b0, 20'd0, 10'd0, k == n - 1);
            end
            if (k == abort_at) return;
        end
        step(sel, poke, 1'b0, 20'd0);
        expect_out(sel, {tag, ".flush"}, 1'b0, 20'd0, 10'd0, 1'b0);
        if (poke) begin
            for (int i = 0; i < 2 * w; i++) begin
                step(sel, 1'b0, 1'b1, 20'($urandom));
                expect_out(sel, {tag, ".idle"}, 1'b0, 20'd0, 10'd0, 1'b0);
            end
        end
        set_in(sel, 1'b0, 1'b0, 20'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        set_in(0, 1'b0, 1'b0, 20'd0);
        set_in(1, 1'b0, 1'b0, 20'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst.data4", 32'(b4.pool_data), 32'd0);
        check("rst.addr4", 32'(b4.pool_addr), 32'd0);
        check("rst.req4", 32'(b4.pool_req), 32'd0);
        check("rst.done4", 32'(b4.done), 32'd0);
        check("rst.req5", 32'(b5.pool_req), 32'd0);
        reset = 1'b1;

        // Ramp 1..16, back-to-back.
        for (int i = 0; i < 16; i++) smp[i] = 20'(i + 1);
        run_frame(0, 4, 4, 0, 1'b0, -1, "t1");

        // All -5: ReLU clamps every window to zero.
        for (int i = 0; i < 16; i++) smp[i] = 20'hFFFFB;
        run_frame(0, 4, 4, 0, 1'b0, -1, "t2");

        // Ramp with in_valid low every other cycle.
        for (int i = 0; i < 16; i++) smp[i] = 20'(i + 1);
        run_frame(0, 4, 4, 1, 1'b0, -1, "t3");

        // Odd 5x5 map: last column and row dropped.
        for (int i = 0; i < 25; i++) smp[i] = 20'(i + 1);
        run_frame(1, 5, 5, 0, 1'b0, -1, "t4");

        // Reset after sample 10, then a clean restart.
        for (int i = 0; i < 16; i++) smp[i] = 20'(i + 1);
        run_frame(0, 4, 4, 0, 1'b0, 9, "t5a");
        set_in(0, 1'b0, 1'b1, 20'd99);
        reset = 1'b0;
        #1;
        check("t5.rst_req", 32'(b4.pool_req), 32'd0);
        check("t5.rst_done", 32'(b4.done), 32'd0);
        check("t5.rst_data", 32'(b4.pool_data), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(0, 1'b0, 1'b1, 20'($urandom));
            expect_out(0, "t5.nostart", 1'b0, 20'd0, 10'd0, 1'b0);
        end
        run_frame(0, 4, 4, 0, 1'b0, -1, "t5b");

        // in_valid while IDLE, start during RUN/FLUSH.
        for (int i = 0; i < 5; i++) begin
            step(0, 1'b0, 1'b1, 20'($urandom));
            expect_out(0, "t6.idle", 1'b0, 20'd0, 10'd0, 1'b0);
        end
        run_frame(0, 4, 4, 2, 1'b1, -1, "t6");

        // Randomized frames with random gaps, both geometries.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 25; i++)
                smp[i] = ($urandom_range(3, 0) == 0) ? 20'($urandom) | 20'h80000 : 20'($urandom_range(1000, 0));
            run_frame(0, 4, 4, 2, 1'b0, -1, $sformatf("r4_%0d", r));
            run_frame(1, 5, 5, 2, r[0], -1, $sformatf("r5_%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
